conv_load_sched: RTL and testbench

Controller that sequences one convolution layer's weight/bias storage. It fetches biases and filter weights from a word-addressed parameter memory and streams them into the weight/bias array using the array's `control_bias` and `control_weight` load strobes. It then paces the compute pass batch-by-batch, channel-by-channel and pixel-by-pixel with a valid/ready step handshake to the conv engine. It sits between the layer-level top FSM and the weight array.

---
 rtl/conv_sched_pkg.sv | 21 ++
 rtl/nest_counter.sv | 53 +++++
 rtl/conv_load_sched.sv | 209 ++++++++++++++++++++
 tb/tb_conv_load_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared constants for conv_load_sched: FSM state codes, read timeout limit, index width helper.
package conv_sched_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LD_BIAS   = 3'd1;
  localparam logic [2:0] S_LD_WEIGHT = 3'd2;
  localparam logic [2:0] S_COMPUTE   = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam int unsigned TIMEOUT_LIM = 255;

  // Index width for a count of n; a single-valued index still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_BATCH_W   = idx_w(3);
  localparam int unsigned DEF_CHANNEL_W = idx_w(1);
  localparam int unsigned DEF_PIXEL_W   = idx_w(64);

endpackage

// File: rtl/nest_counter.sv
// Three-level nested counter (level 0 fastest) with clear, enable,
// per-level roll-over flags and a flag marking the very last count.
module nest_counter
  import conv_sched_pkg::*;
#(
  parameter int unsigned N0 = 64,
  parameter int unsigned N1 = 1,
  parameter int unsigned N2 = 3
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 en,
  input  logic                 clr,
  output logic [idx_w(N0)-1:0] c0,
  output logic [idx_w(N1)-1:0] c1,
  output logic [idx_w(N2)-1:0] c2,
  output logic                 wrap0,
  output logic                 wrap1,
  output logic                 last
);
  localparam int unsigned W0 = idx_w(N0);
  localparam int unsigned W1 = idx_w(N1);
  localparam int unsigned W2 = idx_w(N2);

  assign wrap0 = (c0 == W0'(N0 - 1));
  assign wrap1 = wrap0 && (c1 == W1'(N1 - 1));
  assign last  = wrap1 && (c2 == W2'(N2 - 1));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
    end else if (clr) begin
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
    end else if (en) begin
      if (wrap0) begin
        c0 <= '0;
        if (wrap1) begin
          c1 <= '0;
          c2 <= last ? '0 : c2 + 1'b1;
        end else begin
          c1 <= c1 + 1'b1;
        end
      end else begin
        c0 <= c0 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_load_sched.sv
// Loads biases then weights from parameter memory into the weight array, then paces compute steps.
// Optional read timeout with sticky err is enabled by defining SCHED_TIMEOUT_EN.
module conv_load_sched
  import conv_sched_pkg::*;
#(
  parameter int unsigned BIT     = 32,
  parameter int unsigned CHANNEL = 1,
  parameter int unsigned COL     = 8,
  parameter int unsigned ROW     = 8,
  parameter int unsigned F_COL   = 3,
  parameter int unsigned F_ROW   = 3,
  parameter int unsigned BATCH   = 3,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic                          start,
  input  logic                          abort,
  input  logic [ADDR_W-1:0]             bias_base,
  input  logic [ADDR_W-1:0]             weight_base,
  output logic                          mem_rd,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_rvalid,
  input  logic [BIT-1:0]                mem_rdata,
  output logic                          control_bias,
  output logic                          control_weight,
  output logic [BIT-1:0]                param_data,
  output logic                          step_valid,
  input  logic                          step_ready,
  output logic [idx_w(BATCH)-1:0]       cur_batch,
  output logic [idx_w(CHANNEL)-1:0]     cur_channel,
  output logic [idx_w(ROW*COL)-1:0]     cur_pixel,
  output logic                          ready_fb,
  output logic                          fb_bias,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);
  // state     | meaning
  // IDLE      | waiting for start
  // LD_BIAS   | fetching BATCH bias words, one read outstanding
  // LD_WEIGHT | fetching filter taps in tap/channel/batch order
  // COMPUTE   | offering steps, pixel fastest, then channel, then batch
  // DONE      | one-cycle completion pulse
  localparam int unsigned TAPS = F_ROW * F_COL;

  logic [2:0]              state;
  logic                    pending;
  logic                    to_fire;
  logic                    ld_last;
  logic [ADDR_W-1:0]       bias_b, weight_b, idx, idx_nx, cur_base;
  logic                    w_en, w_clr, w_wrap0, w_wrap1, w_last;
  logic [idx_w(TAPS)-1:0]  w_c0;
  logic [idx_w(CHANNEL)-1:0] w_c1;
  logic [idx_w(BATCH)-1:0] w_c2;
  logic                    s_en, s_clr, s_wrap0, s_wrap1, s_last;
  logic                    unused_cnt;

  assign idx_nx   = idx + 1'b1;
  assign cur_base = (state == S_LD_BIAS) ? bias_b : weight_b;
  assign ld_last  = (state == S_LD_BIAS) ? (idx == ADDR_W'(BATCH - 1)) : w_last;

  assign w_en  = (state == S_LD_WEIGHT) && pending && mem_rvalid && !abort;
  assign w_clr = abort || (state != S_LD_WEIGHT);
  assign s_en  = (state == S_COMPUTE) && step_valid && step_ready && !abort;
  assign s_clr = abort || (state != S_COMPUTE);

  nest_counter #(.N0(TAPS), .N1(CHANNEL), .N2(BATCH)) u_weight_cnt (
    .clk(clk), .rst_(rst_), .en(w_en), .clr(w_clr),
    .c0(w_c0), .c1(w_c1), .c2(w_c2),
    .wrap0(w_wrap0), .wrap1(w_wrap1), .last(w_last)
  );

  // The step counter registers are the index outputs themselves.
  nest_counter #(.N0(ROW * COL), .N1(CHANNEL), .N2(BATCH)) u_step_cnt (
    .clk(clk), .rst_(rst_), .en(s_en), .clr(s_clr),
    .c0(cur_pixel), .c1(cur_channel), .c2(cur_batch),
    .wrap0(s_wrap0), .wrap1(s_wrap1), .last(s_last)
  );

  assign unused_cnt = ^{w_c0, w_c1, w_c2, w_wrap0, w_wrap1, s_wrap0};

`ifdef SCHED_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Down-counter reloads whenever no read is waiting; terminal count 1 marks the last allowed cycle.
  assign to_fire = pending && !mem_rvalid && (to_cnt == 8'd1);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      to_cnt <= 8'(TIMEOUT_LIM);
    else if (abort || !pending || mem_rvalid)
      to_cnt <= 8'(TIMEOUT_LIM);
    else
      to_cnt <= to_cnt - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      err <= 1'b0;
    else if (to_fire && !abort)
      err <= 1'b1;
  end
`else
  assign to_fire = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state          <= S_IDLE;
      pending        <= 1'b0;
      bias_b         <= '0;
      weight_b       <= '0;
      idx            <= '0;
      mem_rd         <= 1'b0;
      mem_addr       <= '0;
      control_bias   <= 1'b0;
      control_weight <= 1'b0;
      param_data     <= '0;
      step_valid     <= 1'b0;
      ready_fb       <= 1'b0;
      fb_bias        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      mem_rd         <= 1'b0;
      control_bias   <= 1'b0;
      control_weight <= 1'b0;
      ready_fb       <= 1'b0;
      done           <= 1'b0;
      if (abort) begin
        state      <= S_IDLE;
        pending    <= 1'b0;
        idx        <= '0;
        mem_addr   <= '0;
        param_data <= '0;
        step_valid <= 1'b0;
        fb_bias    <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              bias_b   <= bias_base;
              weight_b <= weight_base;
              idx      <= '0;
              state    <= S_LD_BIAS;
              busy     <= 1'b1;
              mem_rd   <= 1'b1;
              mem_addr <= bias_base;
              pending  <= 1'b1;
            end
          end
          S_LD_BIAS, S_LD_WEIGHT: begin
            if (pending && mem_rvalid) begin
              control_bias   <= (state == S_LD_BIAS);
              control_weight <= (state == S_LD_WEIGHT);
              param_data     <= mem_rdata;
              if (!ld_last) begin
                idx      <= idx_nx;
                mem_rd   <= 1'b1;
                mem_addr <= cur_base + idx_nx;
              end else if (state == S_LD_BIAS) begin
                state    <= S_LD_WEIGHT;
                idx      <= '0;
                mem_rd   <= 1'b1;
                mem_addr <= weight_b;
              end else begin
                state    <= S_COMPUTE;
                idx      <= '0;
                pending  <= 1'b0;
                fb_bias  <= 1'b1;
              end
            end else if (to_fire) begin
              state   <= S_IDLE;
              pending <= 1'b0;
              idx     <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
          S_COMPUTE: begin
            if (!step_valid) begin
              step_valid <= 1'b1;
            end else if (step_ready) begin
              ready_fb <= s_wrap1;
              if (s_last) begin
                state      <= S_DONE;
                step_valid <= 1'b0;
                fb_bias    <= 1'b0;
                done       <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_load_sched.sv
// Bench for conv_load_sched: random bases, memory latency and step_ready against a queue-based reference.
module tb_conv_load_sched;
  localparam int BATCH = 3, CHANNEL = 1, ROW = 8, COL = 8, F_ROW = 3, F_COL = 3;
  localparam int NB = BATCH;
  localparam int NW = F_ROW * F_COL * CHANNEL * BATCH;
  localparam int RC = ROW * COL;
  localparam int NS = BATCH * CHANNEL * RC;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] bias_base = '0, weight_base = '0, mem_addr;
  logic        mem_rd, mem_rvalid = 1'b0, step_ready = 1'b0;
  logic [31:0] mem_rdata = '0, param_data;
  logic        control_bias, control_weight, step_valid, ready_fb, fb_bias, busy, done, err;
  logic [1:0]  cur_batch;
  logic [0:0]  cur_channel;
  logic [5:0]  cur_pixel;

  conv_load_sched dut (
    .clk(clk), .rst_(rst_), .start(start), .abort(abort),
    .bias_base(bias_base), .weight_base(weight_base),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .control_bias(control_bias), .control_weight(control_weight), .param_data(param_data),
    .step_valid(step_valid), .step_ready(step_ready),
    .cur_batch(cur_batch), .cur_channel(cur_channel), .cur_pixel(cur_pixel),
    .ready_fb(ready_fb), .fb_bias(fb_bias), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // environment knobs and observation logs
  int lat_min = 1, lat_max = 1;
  bit rdy_rand = 1'b0, mem_hold = 1'b0, spur_req = 1'b0;
  bit req_active = 1'b0, pend_unacc = 1'b0;
  int req_wait = 0;
  logic [15:0] req_addr = '0;
  logic [8:0]  prev_idx = '0;
  logic [15:0] addr_q[$];
  logic [32:0] strobe_q[$];
  logic [8:0]  acc_q[$];
  int fb_at[$];
  int done_cnt = 0, w_cnt = 0, stall_err = 0, fbb_err = 0, both_err = 0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction

  always @(negedge clk) begin
    if (!rst_) begin
      mem_rvalid = 1'b0;
      req_active = 1'b0;
      pend_unacc = 1'b0;
      step_ready = 1'b0;
    end else begin
      if (mem_rd) addr_q.push_back(mem_addr);
      if (control_bias) strobe_q.push_back({1'b0, param_data});
      if (control_weight) begin
        strobe_q.push_back({1'b1, param_data});
        w_cnt++;
      end
      if (control_bias && control_weight) both_err++;
      if (ready_fb) fb_at.push_back(acc_q.size());
      if (done) done_cnt++;
      if (step_valid && !fb_bias) fbb_err++;
      mem_rvalid = 1'b0;
      if (req_active) begin
        if (req_wait <= 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(req_addr);
          req_active = 1'b0;
        end else begin
          req_wait--;
        end
      end else if (spur_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        spur_req   = 1'b0;
      end
      if (mem_rd && !mem_hold) begin
        req_active = 1'b1;
        req_wait   = $urandom_range(lat_max, lat_min);
        req_addr   = mem_addr;
      end
      step_ready = rdy_rand ? ($urandom_range(1, 0) == 1) : 1'b1;
      if (step_valid) begin
        if (pend_unacc && ({cur_batch, cur_channel, cur_pixel} != prev_idx)) stall_err++;
        prev_idx   = {cur_batch, cur_channel, cur_pixel};
        pend_unacc = !step_ready;
        if (step_ready) acc_q.push_back(prev_idx);
      end else begin
        pend_unacc = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_q.delete();
    strobe_q.delete();
    acc_q.delete();
    fb_at.delete();
    done_cnt = 0; w_cnt = 0; stall_err = 0; fbb_err = 0; both_err = 0;
  endtask

  // Reference: linear bias then weight addresses, words from mem_word, steps in batch/channel/pixel nesting.
  task automatic check_layer(input logic [15:0] bb, input logic [15:0] wb);
    logic [15:0] ea;
    logic [8:0]  es[$];
    chk("n_reads", 64'(addr_q.size()), 64'(NB + NW));
    chk("n_strobes", 64'(strobe_q.size()), 64'(NB + NW));
    for (int i = 0; i < NB + NW; i++) begin
      ea = (i < NB) ? bb + 16'(i) : wb + 16'(i - NB);
      chk("read_addr", (i < addr_q.size()) ? 64'(addr_q[i]) : '1, 64'(ea));
      chk("strobe_word", (i < strobe_q.size()) ? 64'(strobe_q[i]) : '1,
          64'({(i >= NB), mem_word(ea)}));
    end
    for (int b = 0; b < BATCH; b++)
      for (int c = 0; c < CHANNEL; c++)
        for (int p = 0; p < RC; p++)
          es.push_back({2'(b), 1'(c), 6'(p)});
    chk("n_steps", 64'(acc_q.size()), 64'(NS));
    for (int k = 0; k < NS; k++)
      chk("step_idx", (k < acc_q.size()) ? 64'(acc_q[k]) : '1, 64'(es[k]));
    chk("n_ready_fb", 64'(fb_at.size()), 64'(BATCH));
    for (int k = 0; k < BATCH; k++)
      chk("ready_fb_at", (k < fb_at.size()) ? 64'(fb_at[k]) : '1, 64'((k + 1) * CHANNEL * RC));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("stall_stable", 64'(stall_err), 64'd0);
    chk("fb_bias_in_compute", 64'(fbb_err), 64'd0);
    chk("one_strobe", 64'(both_err), 64'd0);
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  task automatic run_layer(input logic [15:0] bb, input logic [15:0] wb, input bit rr,
                           input int lmin, input int lmax, input bit inject);
    clear_logs();
    rdy_rand = rr; lat_min = lmin; lat_max = lmax;
    bias_base = bb; weight_base = wb;
    start = 1'b1;
    for (int n = 0; n < 5000 && done_cnt == 0; n++) begin
      tick();
      start = (inject && n == 40);
      if (inject && n == 40) begin
        bias_base = ~bb;
        weight_base = ~wb;
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(done_cnt != 0), 64'd1);
    repeat (3) tick();
    check_layer(bb, wb);
  endtask

  initial begin
    logic [15:0] bb, wb;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {mem_rd, control_bias, control_weight, step_valid, ready_fb,
                      fb_bias, busy, done, err}, 64'd0);
    chk("reset_data", {mem_addr, param_data, cur_batch, cur_channel, cur_pixel}, 64'd0);
    rst_ = 1'b1;
    tick();

    // nominal: latency 1, always ready
    bb = 16'($urandom); wb = 16'($urandom);
    run_layer(bb, wb, 1'b0, 1, 1, 1'b0);

    // bias address wrap, random latency and stalls, start pulse while busy
    wb = 16'($urandom);
    run_layer(16'hFFFE, wb, 1'b1, 1, 4, 1'b1);
    chk("wrap_addr0", 64'(addr_q[0]), 64'h FFFE);
    chk("wrap_addr1", 64'(addr_q[1]), 64'h FFFF);
    chk("wrap_addr2", 64'(addr_q[2]), 64'h0000);

    // abort after 10 weights
    clear_logs();
    rdy_rand = 1'b0; lat_min = 1; lat_max = 1;
    bias_base = 16'($urandom); weight_base = 16'($urandom);
    start = 1'b1;
    for (n = 0; n < 500 && w_cnt < 10; n++) begin
      tick();
      start = 1'b0;
    end
    chk("abort_reached", 64'(w_cnt), 64'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_strobes", 64'(strobe_q.size()), 64'(NB + 10));
    repeat (20) tick();
    chk("no_strobe_after_abort", 64'(strobe_q.size()), 64'(NB + 10));
    chk("abort_no_err", 64'(err), 64'd0);
    bb = 16'($urandom); wb = 16'($urandom);
    run_layer(bb, wb, 1'b1, 1, 3, 1'b0);

    // asynchronous reset during compute
    clear_logs();
    rdy_rand = 1'b0;
    start = 1'b1;
    for (n = 0; n < 500 && !step_valid; n++) begin
      tick();
      start = 1'b0;
    end
    chk("compute_reached", 64'(step_valid), 64'd1);
    repeat (5) tick();
    rst_ = 1'b0;
    #1;
    chk("async_rst_ctl", {mem_rd, control_bias, control_weight, step_valid, ready_fb,
                          fb_bias, busy, done, err}, 64'd0);
    chk("async_rst_data", {mem_addr, param_data, cur_batch, cur_channel, cur_pixel}, 64'd0);
    tick();
    rst_ = 1'b1;
    repeat (2) tick();

    // spurious rvalid while idle
    clear_logs();
    spur_req = 1'b1;
    repeat (4) tick();
    chk("spurious_no_strobe", 64'(strobe_q.size()), 64'd0);
    chk("spurious_idle", 64'(busy), 64'd0);

    // withheld read data
    clear_logs();
    mem_hold = 1'b1;
    start = 1'b1;
    for (n = 1; n <= 400; n++) begin
      tick();
      start = 1'b0;
      if (err) break;
    end
`ifdef SCHED_TIMEOUT_EN
    chk("timeout_cycle", 64'(n), 64'd256);
    chk("timeout_done", 64'(done), 64'd1);
    chk("timeout_idle", 64'(busy), 64'd0);
    tick();
    chk("timeout_done_pulse", 64'(done), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("err_sticky", 64'(err), 64'd1);
`else
    chk("wait_forever_busy", 64'(busy), 64'd1);
    chk("no_timeout_err", 64'(err), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_from_wait", 64'(busy), 64'd0);
`endif
    mem_hold = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
